// File: rtl/bwm_pkg.sv
// Shared definitions for the pipelined Baugh-Wooley multiplier: the
// two's-complement correction constant and the rows-per-stage rule.
package bwm_pkg;

    localparam int unsigned BWM_MAX_N = 32;

    // Constant added once per signed operation: 2^n + 2^(2n-1), kept in a
    // 64-bit container so every legal n (2..32) fits; callers slice to 2n bits.
    function automatic logic [2*BWM_MAX_N-1:0] bwm_corr(input int unsigned n);
        logic [2*BWM_MAX_N-1:0] c;
        c = {(2*BWM_MAX_N){1'b0}};
        c[n] = 1'b1;
        c[2*n-1] = 1'b1;
        return c;
    endfunction

    // Number of partial-product rows folded into each pipeline stage.
    function automatic int unsigned bwm_rows(input int unsigned n, input int unsigned stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/bwm_pp_row.sv
// One partial-product row of the Baugh-Wooley array, already shifted to its
// weight. In signed mode the terms where exactly one index is the sign
// position are inverted; the matching correction constant is added elsewhere.
module bwm_pp_row #(
    parameter int N   = 8,
    parameter int ROW = 0
) (
    input  logic [N-1:0]   a,
    input  logic           b_bit,
    input  logic           tc,
    output logic [2*N-1:0] pp
);

    // Build row ROW: bit j lands at weight 2^(ROW+j).
    always_comb begin
        pp = {(2*N){1'b0}};
        for (int j = 0; j < N; j++) begin
            pp[ROW+j] = (a[j] & b_bit) ^ (tc & ((ROW == N-1) != (j == N-1)));
        end
    end

endmodule

// File: rtl/bwm_pipe.sv
// Pipelined Baugh-Wooley multiplier with per-operation signed/unsigned mode.
// Each stage folds N/STAGES partial-product rows into a running 2N-bit sum.
// A single global advance enable gives full backpressure: when the output
// holds an unconsumed product, every stage freezes.
module bwm_pipe
    import bwm_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_tc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           out_tc
);

    localparam int W = 2 * N;
    localparam int R = bwm_rows(N, STAGES);
    localparam logic [2*BWM_MAX_N-1:0] CORR_FULL = bwm_corr(N);
    localparam logic [W-1:0] CORR = CORR_FULL[W-1:0];

    if ((N < 2) || (N > 32) || (STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_bad_params
        $error("bwm_pipe: illegal N/STAGES combination");
    end

    logic adv_s;

    // Global advance: the pipe moves unless a product is waiting unconsumed.
    always_comb begin
        adv_s = (!g_stage[STAGES-1].vld_q) || out_ready;
    end

    assign in_ready  = adv_s;
    assign out_valid = g_stage[STAGES-1].vld_q;
    assign out_p     = g_stage[STAGES-1].sum_q;
    assign out_tc    = g_stage[STAGES-1].tc_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic           vin_s;
        logic           tcin_s;
        logic [N-1:0]   ain_s;
        logic [N-1:0]   bin_s;
        logic [W-1:0]   base_s;
        logic [W-1:0]   sum_s;
        logic [W-1:0]   pp_s [R];

        logic           vld_d, vld_q;
        logic           tc_d, tc_q;
        logic [N-1:0]   a_d, a_q;
        logic [N-1:0]   b_d, b_q;
        logic [W-1:0]   sum_d, sum_q;

        if (s == 0) begin : g_head
            assign vin_s  = in_valid;
            assign tcin_s = in_tc;
            assign ain_s  = in_a;
            assign bin_s  = in_b;
            assign base_s = in_tc ? CORR : {W{1'b0}};
        end else begin : g_link
            assign vin_s  = g_stage[s-1].vld_q;
            assign tcin_s = g_stage[s-1].tc_q;
            assign ain_s  = g_stage[s-1].a_q;
            assign bin_s  = g_stage[s-1].b_q;
            assign base_s = g_stage[s-1].sum_q;
        end

        for (genvar r = 0; r < R; r++) begin : g_row
            bwm_pp_row #(
                .N  (N),
                .ROW(s*R + r)
            ) u_row (
                .a    (ain_s),
                .b_bit(bin_s[s*R + r]),
                .tc   (tcin_s),
                .pp   (pp_s[r])
            );
        end

        // Fold this stage's rows into the incoming running sum.
        always_comb begin
            sum_s = base_s;
            for (int r = 0; r < R; r++) begin
                sum_s = sum_s + pp_s[r];
            end
        end

        // Next state: load on advance with valid data, bubble on advance
        // without data (data kept so out_p stays put), hold on stall.
        always_comb begin
            vld_d = vld_q;
            tc_d  = tc_q;
            a_d   = a_q;
            b_d   = b_q;
            sum_d = sum_q;
            if (adv_s) begin
                vld_d = vin_s;
                if (vin_s) begin
                    tc_d  = tcin_s;
                    a_d   = ain_s;
                    b_d   = bin_s;
                    sum_d = sum_s;
                end else begin
                    sum_d = sum_q;
                end
            end else begin
                vld_d = vld_q;
            end
        end

        // Stage register with synchronous reset that discards in-flight work.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                tc_q  <= 1'b0;
                a_q   <= {N{1'b0}};
                b_q   <= {N{1'b0}};
                sum_q <= {W{1'b0}};
            end else begin
                vld_q <= vld_d;
                tc_q  <= tc_d;
                a_q   <= a_d;
                b_q   <= b_d;
                sum_q <= sum_d;
            end
        end
    end

endmodule

// File: tb/tb_bwm_pipe.sv
// Bench for bwm_pipe: three configurations (N=4/S=2, N=8/S=4, N=8/S=1) are
// driven with directed and random traffic; a queue model per instance holds
// the products that must emerge, computed by ordinary integer multiplication.
module tb_bwm_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] v;
    logic [2:0] tc;
    logic [2:0] ordy;
    logic [7:0] a [3];
    logic [7:0] b [3];
    wire  [2:0] ir;
    wire  [2:0] ov;
    wire  [2:0] otc;
    wire  [7:0]  p0_w;
    wire  [15:0] p1_w;
    wire  [15:0] p2_w;

    int checks = 0;
    int errors = 0;

    logic [16:0] qb [3][64];
    int          hd [3];
    int          tl [3];
    int          npop [3];
    logic        hold_v [3];
    logic [15:0] hold_p [3];
    logic        hold_tc [3];
    logic        pend_rst [3];

    bwm_pipe #(.N(4), .STAGES(2)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(v[0]), .in_ready(ir[0]),
        .in_a(a[0][3:0]), .in_b(b[0][3:0]), .in_tc(tc[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(p0_w), .out_tc(otc[0]));

    bwm_pipe #(.N(8), .STAGES(4)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(v[1]), .in_ready(ir[1]),
        .in_a(a[1]), .in_b(b[1]), .in_tc(tc[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(p1_w), .out_tc(otc[1]));

    bwm_pipe #(.N(8), .STAGES(1)) u2 (
        .clk(clk), .rst(rst[2]), .in_valid(v[2]), .in_ready(ir[2]),
        .in_a(a[2]), .in_b(b[2]), .in_tc(tc[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_p(p2_w), .out_tc(otc[2]));

    function automatic int nw(int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int stg(int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] p_of(int k);
        case (k)
            0:       return {8'h00, p0_w};
            1:       return p1_w;
            default: return p2_w;
        endcase
    endfunction

    // Reference product: interpret operands as n-bit signed or unsigned
    // integers, multiply, keep 2n bits.
    function automatic logic [15:0] ref_prod(int n, logic [7:0] x, logic [7:0] y, logic t);
        longint xa, ya, pr, m;
        m  = (longint'(1) << n) - 1;
        xa = longint'(x) & m;
        ya = longint'(y) & m;
        if (t && xa[n-1]) xa = xa - (longint'(1) << n);
        if (t && ya[n-1]) ya = ya - (longint'(1) << n);
        pr = xa * ya;
        pr = pr & ((longint'(1) << (2*n)) - 1);
        return pr[15:0];
    endfunction

    // Compare process: mid-cycle, check handshake, reset state, stall
    // stability and every delivered product against the queue model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== (!ov[k] || ordy[k])) begin
                errors++;
                $display("FAIL in_ready[%0d] got %b want %b", k, ir[k], !ov[k] || ordy[k]);
            end
            if (rst[k]) begin
                hd[k] = 0;
                tl[k] = 0;
                hold_v[k] = 1'b0;
                pend_rst[k] = 1'b1;
            end else begin
                if (pend_rst[k]) begin
                    checks++;
                    if (ov[k] !== 1'b0 || p_of(k) !== 16'h0000 || otc[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_state[%0d] got v=%b p=%h tc=%b want 0 0 0", k, ov[k], p_of(k), otc[k]);
                    end
                    pend_rst[k] = 1'b0;
                end
                if (hold_v[k] && ov[k]) begin
                    checks++;
                    if (p_of(k) !== hold_p[k] || otc[k] !== hold_tc[k]) begin
                        errors++;
                        $display("FAIL stall_hold[%0d] got %h/%b want %h/%b", k, p_of(k), otc[k], hold_p[k], hold_tc[k]);
                    end
                end
                hold_v[k]  = ov[k] && !ordy[k];
                hold_p[k]  = p_of(k);
                hold_tc[k] = otc[k];
                if (ov[k] && ordy[k]) begin
                    checks++;
                    if (hd[k] == tl[k]) begin
                        errors++;
                        $display("FAIL unexpected_product[%0d] got %h want none", k, p_of(k));
                    end else begin
                        if (p_of(k) !== qb[k][hd[k] % 64][15:0] || otc[k] !== qb[k][hd[k] % 64][16]) begin
                            errors++;
                            $display("FAIL product[%0d] got %h/%b want %h/%b", k, p_of(k), otc[k],
                                     qb[k][hd[k] % 64][15:0], qb[k][hd[k] % 64][16]);
                        end
                        hd[k]++;
                        npop[k]++;
                    end
                end
                if (v[k] && ir[k]) begin
                    qb[k][tl[k] % 64] = {tc[k], ref_prod(nw(k), a[k], b[k], tc[k])};
                    tl[k]++;
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // One operation with ready output; checks exact latency and the literal
    // product. Caller is positioned just after a rising edge.
    task automatic op_lat(int k, logic [7:0] x, logic [7:0] y, logic t, logic [15:0] expv);
        a[k] = x; b[k] = y; tc[k] = t; v[k] = 1'b1;
        check("op_ready", {31'd0, ir[k]}, 32'd1);
        @(posedge clk); #1;
        v[k] = 1'b0;
        for (int e = 1; e < stg(k); e++) begin
            check("early_valid", {31'd0, ov[k]}, 32'd0);
            @(posedge clk); #1;
        end
        check("lat_valid", {31'd0, ov[k]}, 32'd1);
        check("lat_product", {16'd0, p_of(k)}, {16'd0, expv});
        check("lat_tc", {31'd0, otc[k]}, {31'd0, t});
    endtask

    initial begin
        int base;
        logic ir_ok;
        rst = 3'b111; v = 3'b000; tc = 3'b000; ordy = 3'b111;
        for (int k = 0; k < 3; k++) begin
            a[k] = 8'h00; b[k] = 8'h00;
            hd[k] = 0; tl[k] = 0; npop[k] = 0;
            hold_v[k] = 1'b0; hold_p[k] = 16'h0000; hold_tc[k] = 1'b0; pend_rst[k] = 1'b0;
        end
        idle(3);
        rst = 3'b000;
        check("ready_after_reset", {29'd0, ir}, 32'd7);

        // Directed literals, N=4 S=2 and N=8 S=1
        op_lat(0, 8'h08, 8'h08, 1'b1, 16'h0040);
        op_lat(0, 8'h08, 8'h07, 1'b1, 16'h00C8);
        op_lat(0, 8'h0F, 8'h0F, 1'b0, 16'h00E1);
        op_lat(2, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        op_lat(2, 8'h7F, 8'h80, 1'b1, 16'hC080);
        idle(2);

        // Exhaustive N=4, back-to-back
        base = npop[0];
        ir_ok = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    a[0] = 8'(x); b[0] = 8'(y); tc[0] = t[0]; v[0] = 1'b1;
                    if (ir[0] !== 1'b1) ir_ok = 1'b0;
                    idle(1);
                end
            end
        end
        v[0] = 1'b0;
        idle(4);
        check("exh_ready_steady", {31'd0, ir_ok}, 32'd1);
        check("exh_count", 32'(npop[0] - base), 32'd512);

        // Backpressure N=8 S=4: three ops under a 6-cycle stall
        base = npop[1];
        ordy[1] = 1'b0;
        a[1] = 8'h80; b[1] = 8'h80; tc[1] = 1'b1; v[1] = 1'b1; idle(1);
        a[1] = 8'hFF; b[1] = 8'hFF; tc[1] = 1'b0; idle(1);
        a[1] = 8'h05; b[1] = 8'hFD; tc[1] = 1'b1; idle(1);
        v[1] = 1'b0;
        idle(3);
        check("bp_valid", {31'd0, ov[1]}, 32'd1);
        check("bp_ready_low", {31'd0, ir[1]}, 32'd0);
        check("bp_first", {16'd0, p1_w}, 32'h4000);
        ordy[1] = 1'b1;
        idle(6);
        check("bp_count", 32'(npop[1] - base), 32'd3);

        // Reset mid-flight N=8 S=4: two ops discarded
        base = npop[1];
        a[1] = 8'h12; b[1] = 8'h34; tc[1] = 1'b0; v[1] = 1'b1; idle(1);
        a[1] = 8'h9A; b[1] = 8'h05; tc[1] = 1'b1; idle(1);
        v[1] = 1'b0; rst[1] = 1'b1; idle(1);
        rst[1] = 1'b0;
        check("rst_valid", {31'd0, ov[1]}, 32'd0);
        check("rst_product", {16'd0, p1_w}, 32'd0);
        idle(6);
        check("rst_no_output", 32'(npop[1] - base), 32'd0);

        // Reset mid-flight N=4 S=2, then 3*(-2)
        a[0] = 8'h05; b[0] = 8'h06; tc[0] = 1'b0; v[0] = 1'b1; idle(1);
        v[0] = 1'b0; rst[0] = 1'b1; idle(1);
        rst[0] = 1'b0;
        check("rst0_valid", {31'd0, ov[0]}, 32'd0);
        op_lat(0, 8'h03, 8'h0E, 1'b1, 16'h00FA);
        idle(2);

        // Random traffic with random backpressure on all instances
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                v[k]    = 1'($urandom_range(0, 1));
                a[k]    = 8'($urandom);
                b[k]    = 8'($urandom);
                tc[k]   = 1'($urandom_range(0, 1));
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            idle(1);
        end
        v = 3'b000;
        ordy = 3'b111;
        idle(8);
        for (int k = 0; k < 3; k++) begin
            check("drain_empty", 32'(tl[k] - hd[k]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
